// File: rtl/l2_arb_pkg.sv
// l2_arb_pkg: FSM state type and default beat geometry for the L2 load arbiter
package l2_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} l2_arb_state_e;
  localparam int DEF_VLEN = 2048;
  localparam int BEAT_BYTES = DEF_VLEN / 8;
  localparam int OFFS_W = $clog2(BEAT_BYTES);
endpackage

// File: rtl/l2_rr_arbiter.sv
// l2_rr_arbiter: combinational round-robin pick of the first request at or after ptr
module l2_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx
);
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      int k;
      k = int'(ptr) + i;
      k = k >= NREQ ? k - NREQ : k;
      if (req[k]) begin
        gnt = '0;
        gnt[k] = 1'b1;
        idx = IW'(k);
      end
    end
  end
endmodule

// File: rtl/l2_load_arbiter.sv
// l2_load_arbiter: round-robin sharing of one L2 load port; define L2_ARB_ALIGN_CHECK_EN to reject misaligned paddrs
module l2_load_arbiter
  import l2_arb_pkg::*;
#(
  parameter int VLEN = BEAT_BYTES * 8,
  parameter int NREQ = 4,
  parameter int ADDR_W = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*ADDR_W-1:0] req_paddr,
  output logic [NREQ-1:0]        resp_valid,
  input  logic [NREQ-1:0]        resp_ready,
  output logic [VLEN-1:0]        resp_data,
  output logic                   resp_err,
  output logic                   mem_en,
  output logic [ADDR_W-1:0]      mem_paddr,
  input  logic [VLEN-1:0]        mem_data,
  input  logic                   mem_valid
);
  localparam int IW = $clog2(NREQ);
  l2_arb_state_e state;
  logic [IW-1:0] rr_ptr, owner, gnt_idx;
  logic [NREQ-1:0] gnt;
  logic [ADDR_W-1:0] sel_paddr;
  logic accept, misaligned;
  l2_rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
    .req(req_valid),
    .ptr(rr_ptr),
    .gnt(gnt),
    .idx(gnt_idx)
  );
  assign sel_paddr = req_paddr[gnt_idx*ADDR_W +: ADDR_W];
  assign accept = state == IDLE && |req_valid;
  assign req_ready = state == IDLE && !rst ? gnt : '0;
`ifdef L2_ARB_ALIGN_CHECK_EN
  localparam int OW = $clog2(VLEN / 8);
  logic err_q;
  assign misaligned = |sel_paddr[OW-1:0];
  assign resp_err = err_q;
  always_ff @(posedge clk)
    err_q <= rst ? 1'b0 : accept ? misaligned : state == RESP && resp_ready[owner] ? 1'b0 : err_q;
`else
  assign misaligned = 1'b0;
  assign resp_err = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      owner <= '0;
      mem_en <= 1'b0;
      mem_paddr <= '0;
      resp_valid <= '0;
      resp_data <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          owner <= gnt_idx;
          rr_ptr <= gnt_idx == IW'(NREQ - 1) ? '0 : gnt_idx + 1'b1;
          mem_paddr <= sel_paddr;
          if (misaligned) begin
            state <= RESP;
            resp_valid <= gnt;
            resp_data <= '0;
          end else begin
            state <= ISSUE;
            mem_en <= 1'b1;
          end
        end
        ISSUE: begin
          mem_en <= 1'b0;
          state <= WAIT;
        end
        WAIT: if (mem_valid) begin
          resp_data <= mem_data;
          resp_valid <= NREQ'(1) << owner;
          state <= RESP;
        end
        RESP: if (resp_ready[owner]) begin
          resp_valid <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_l2_load_arbiter.sv
// tb_l2_load_arbiter: directed plus randomized checks against a round-robin transaction model
module tb_l2_load_arbiter;
  logic clk, rst, mem_en, mem_valid, resp_err;
  logic [3:0] req_valid, req_ready, resp_valid, resp_ready;
  logic [255:0] req_paddr;
  logic [2047:0] resp_data, mem_data, last_d;
  logic [63:0] mem_paddr;
  int n_chk, n_fail, rr;
  l2_load_arbiter dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_paddr(req_paddr),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_data(resp_data),
    .resp_err(resp_err),
    .mem_en(mem_en),
    .mem_paddr(mem_paddr),
    .mem_data(mem_data),
    .mem_valid(mem_valid)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [2047:0] o, input logic [2047:0] e);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h (low 64 bits)", tag, o[63:0], e[63:0]);
    end
  endtask
  function automatic int pick(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[(rr + i) % 4]) return (rr + i) % 4;
    return -1;
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic txn(input logic [3:0] rv, input logic [63:0] base, input int stall, input bit drop, input logic [3:0] hold_rdy);
    int g;
    logic [3:0] oh;
    logic [2047:0] d;
    g = pick(rv);
    oh = 4'b1 << g;
    for (int i = 0; i < 4; i++) req_paddr[i*64 +: 64] = base + 64'(i) * 64'h1000;
    req_valid = rv;
    #1;
    chk("req_ready_accept", req_ready, oh);
    rr = (g + 1) % 4;
    step();
    if (drop) req_valid = '0;
    chk("mem_en_issue", mem_en, 1);
    chk("mem_paddr_issue", mem_paddr, base + 64'(g) * 64'h1000);
    chk("req_ready_issue", req_ready, 0);
    for (int i = 0; i < 64; i++) d[i*32 +: 32] = $urandom;
    step();
    chk("mem_en_wait", mem_en, 0);
    chk("resp_valid_wait", resp_valid, 0);
    mem_valid = 1'b1;
    mem_data = d;
    resp_ready = stall == 0 ? 4'hF : hold_rdy;
    step();
    mem_valid = 1'b0;
    mem_data = ~d;
    chk("resp_valid_resp", resp_valid, oh);
    chk("resp_data_resp", resp_data, d);
    chk("resp_err_resp", resp_err, 0);
    chk("req_ready_resp", req_ready, 0);
    for (int s = 0; s < stall; s++) begin
      step();
      chk("resp_valid_stall", resp_valid, oh);
      chk("resp_data_stall", resp_data, d);
      chk("mem_en_stall", mem_en, 0);
      chk("req_ready_stall", req_ready, 0);
    end
    if (stall > 0) resp_ready = 4'hF;
    step();
    chk("resp_valid_done", resp_valid, 0);
    last_d = d;
  endtask
  initial begin
    n_chk = 0;
    n_fail = 0;
    rr = 0;
    rst = 1'b1;
    req_valid = 4'hF;
    resp_ready = '0;
    req_paddr = '0;
    mem_data = '0;
    mem_valid = 1'b0;
    step();
    step();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_paddr", mem_paddr, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_resp_err", resp_err, 0);
    req_valid = '0;
    rst = 1'b0;
    step();
    txn(4'b0001, 64'h8000_0000, 0, 1, 4'b0000);
    txn(4'b0011, 64'h9000_0000, 10, 1, 4'b0000);
    req_valid = '0;
    mem_valid = 1'b1;
    mem_data = {64{32'hDEAD_BEEF}};
    step();
    mem_valid = 1'b0;
    chk("stray_resp_valid", resp_valid, 0);
    chk("stray_mem_en", mem_en, 0);
    chk("stray_resp_data", resp_data, last_d);
    step();
    chk("stray_resp_valid2", resp_valid, 0);
    txn(4'b0100, 64'hA000_0000, 3, 1, 4'b0001);
`ifdef L2_ARB_ALIGN_CHECK_EN
    req_paddr[63:0] = 64'h8000_0040;
    req_valid = 4'b0001;
    resp_ready = '0;
    #1;
    chk("mis_req_ready", req_ready, 4'b0001);
    rr = (pick(4'b0001) + 1) % 4;
    step();
    req_valid = '0;
    chk("mis_mem_en", mem_en, 0);
    chk("mis_resp_valid", resp_valid, 4'b0001);
    chk("mis_resp_err", resp_err, 1);
    chk("mis_resp_data", resp_data, 0);
    resp_ready = 4'hF;
    step();
    chk("mis_resp_done", resp_valid, 0);
    chk("mis_err_clear", resp_err, 0);
`else
    txn(4'b0001, 64'h8000_0040, 0, 1, 4'b0000);
`endif
    req_valid = 4'b0010;
    step();
    req_valid = '0;
    step();
    rst = 1'b1;
    step();
    chk("rstw_mem_en", mem_en, 0);
    chk("rstw_resp_valid", resp_valid, 0);
    chk("rstw_req_ready", req_ready, 0);
    chk("rstw_mem_paddr", mem_paddr, 0);
    chk("rstw_resp_data", resp_data, 0);
    rr = 0;
    rst = 1'b0;
    mem_valid = 1'b1;
    mem_data = {64{32'hCAFE_F00D}};
    step();
    mem_valid = 1'b0;
    chk("late_resp_valid", resp_valid, 0);
    chk("late_resp_data", resp_data, 0);
    chk("late_mem_en", mem_en, 0);
    resp_ready = 4'hF;
    for (int k = 0; k < 5; k++) txn(4'hF, 64'hB000_0000, 0, 0, 4'b0000);
    req_valid = '0;
    for (int k = 0; k < 20; k++)
      txn(4'($urandom_range(1, 15)), {$urandom, $urandom} & ~64'hFFFF, $urandom_range(0, 3), 1, 4'b0000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
